// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets one of N_REQ byte streams own a single UART TX
// engine for a whole packet, with a one-byte output register and a burst limit.
module uart_tx_arbiter #(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 64,
  localparam int GW = $clog2(N_REQ),
  localparam int CW = $clog2(MAX_BURST + 1)
) (
  input  logic                   clk,
  input  logic                   srst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ-1:0]       req_last,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   tx_valid,
  output logic [WIDTH-1:0]       tx_data,
  input  logic                   tx_ready,
  output logic [GW-1:0]          grant_id,
  output logic                   busy,
  output logic                   burst_err
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   grant_d;
  logic [CW-1:0]   burst_cnt, burst_cnt_d;
  logic            burst_err_d;

  logic            tx_free;
  logic            accept;
  logic            owner_last;
  logic [WIDTH-1:0] owner_data;

  logic            lo_found, hi_found;
  logic [GW-1:0]   lo_pick, hi_pick, pick;

  assign busy    = (state_q == LOCKED);
  // The output register can take a new byte when empty or draining this cycle.
  assign tx_free = !tx_valid || tx_ready;
  assign accept  = |(req_valid & req_ready);

  // NOTE: every combinational output gets a default before any branch so no
  // path leaves a variable unassigned, which would infer a latch.
  always_comb begin
    req_ready  = '0;
    owner_last = 1'b0;
    owner_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_id == GW'(i)) begin
        req_ready[i] = !srst && (state_q == LOCKED) && tx_free;
        owner_last   = req_last[i];
        owner_data   = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Circular search from grant_id+1: prefer the lowest valid index above the
  // last owner, otherwise wrap to the lowest valid index overall.
  always_comb begin
    lo_found = 1'b0;
    hi_found = 1'b0;
    lo_pick  = grant_id;
    hi_pick  = grant_id;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        lo_found = 1'b1;
        lo_pick  = GW'(i);
        if (GW'(i) > grant_id) begin
          hi_found = 1'b1;
          hi_pick  = GW'(i);
        end
      end
    end
    pick = hi_found ? hi_pick : lo_pick;
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_id;
    burst_cnt_d = burst_cnt;
    burst_err_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (lo_found) begin
          grant_d     = pick;
          state_d     = LOCKED;
          burst_cnt_d = '0;
        end
      end
      LOCKED: begin
        if (accept) begin
          burst_cnt_d = burst_cnt + 1'b1;
          if (owner_last) begin
            state_d = IDLE;
          end else if (burst_cnt_d == CW'(MAX_BURST)) begin
            state_d     = IDLE;
            burst_err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (srst) begin
      state_q   <= IDLE;
      grant_id  <= GW'(N_REQ - 1);
      burst_cnt <= '0;
      burst_err <= 1'b0;
      tx_valid  <= 1'b0;
      tx_data   <= '0;
    end else begin
      state_q   <= state_d;
      grant_id  <= grant_d;
      burst_cnt <= burst_cnt_d;
      burst_err <= burst_err_d;
      if (accept) begin
        tx_data  <= owner_data;
        tx_valid <= 1'b1;
      end else if (tx_ready) begin
        tx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: per-requester byte queues drive the
// inputs, expected TX bytes are queued in hand-computed order and checked on handshake.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MB = 4;

  logic           clk = 1'b0;
  logic           srst;
  logic [N-1:0]   req_valid, req_last, req_ready;
  logic [N*W-1:0] req_data;
  logic           tx_valid, tx_ready;
  logic [W-1:0]   tx_data;
  logic [1:0]     grant_id;
  logic           busy, burst_err;

  uart_tx_arbiter #(.N_REQ(N), .WIDTH(W), .MAX_BURST(MB)) dut (
    .clk(clk), .srst(srst),
    .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
    .req_ready(req_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .grant_id(grant_id), .busy(busy), .burst_err(burst_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [8:0] rq [N][$];   // {last, data} per requester
  logic [7:0] sb [$];      // expected TX byte order
  logic [1:0] glog [$];    // owner index at each requester accept
  logic [N-1:0] acc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic enq(input int id, input logic [7:0] d, input logic l);
    rq[id].push_back({l, d});
  endtask

  function automatic int pending();
    int p;
    p = sb.size() + int'(busy) + int'(tx_valid);
    for (int i = 0; i < N; i++) p += rq[i].size();
    return p;
  endfunction

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && pending() != 0; i++) cyc(1);
    check("drain", pending(), 0);
  endtask

  task automatic flush();
    for (int i = 0; i < N; i++) rq[i].delete();
    sb.delete();
    glog.delete();
  endtask

  task automatic do_reset();
    srst = 1'b1;
    flush();
    cyc(2);
    srst = 1'b0;
  endtask

  // Requester drivers: accept sampled mid-cycle, queue advanced after the edge.
  // Idle requesters show req_last=1 so a stray last with valid low is exercised.
  initial begin
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    acc       = '0;
    forever begin
      @(negedge clk);
      acc = req_valid & req_ready;
      if (acc != '0) glog.push_back(grant_id);
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        logic [8:0] head;
        if (acc[i] && rq[i].size() != 0) void'(rq[i].pop_front());
        head = (rq[i].size() != 0) ? rq[i][0] : 9'h1EE;
        req_valid[i]           = (rq[i].size() != 0);
        req_last[i]            = head[8];
        req_data[i*W +: W]     = head[7:0];
      end
      acc = '0;
    end
  end

  // TX monitor
  initial begin
    forever begin
      @(negedge clk);
      if (!srst && tx_valid && tx_ready) begin
        if (sb.size() == 0) check("tx_expected_present", sb.size(), 1);
        else check("tx_data", tx_data, sb.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] t1 [4];
    t1 = '{8'h55, 8'hAA, 8'h00, 8'hFF};
    srst     = 1'b1;
    tx_ready = 1'b1;
    cyc(3);
    check("rst_tx_valid",  tx_valid,  0);
    check("rst_busy",      busy,      0);
    check("rst_burst_err", burst_err, 0);
    check("rst_tx_data",   tx_data,   0);
    check("rst_grant",     grant_id,  3);
    check("rst_ready",     req_ready, 0);

    // Single requester, back-to-back bytes
    for (int k = 0; k < 4; k++) begin
      enq(0, t1[k], k == 3);
      sb.push_back(t1[k]);
    end
    cyc(1);
    check("ready_in_reset", req_ready, 0);
    srst = 1'b0;
    #1;
    check("ready_first_cycle", req_ready, 0);
    cyc(1);
    check("t1_busy",  busy,      1);
    check("t1_grant", grant_id,  0);
    check("t1_ready", req_ready, 4'b0001);
    for (int k = 0; k < 4; k++) begin
      cyc(1);
      check("t1_stream_data",  tx_data,  t1[k]);
      check("t1_stream_valid", tx_valid, 1);
    end
    check("t1_busy_fall", busy,      0);
    check("t1_no_berr",   burst_err, 0);
    check("t1_grant_end", grant_id,  0);
    wait_drain(20);

    // Round robin from reset, then wrap after owner 2, then sole re-grant
    do_reset();
    enq(0, 8'h10, 1'b1); enq(1, 8'h11, 1'b1); enq(2, 8'h12, 1'b1);
    sb.push_back(8'h10); sb.push_back(8'h11); sb.push_back(8'h12);
    wait_drain(40);
    check("rr_count", glog.size(), 3);
    check("rr_g0", glog[0], 0);
    check("rr_g1", glog[1], 1);
    check("rr_g2", glog[2], 2);
    glog.delete();
    enq(0, 8'h20, 1'b1); enq(1, 8'h21, 1'b1);
    sb.push_back(8'h20); sb.push_back(8'h21);
    wait_drain(40);
    check("rr_wrap_g0", glog[0], 0);
    check("rr_wrap_g1", glog[1], 1);
    glog.delete();
    enq(1, 8'h22, 1'b1);
    sb.push_back(8'h22);
    wait_drain(20);
    check("rr_regrant_same", glog[0], 1);

    // Backpressure with 0x3C held
    tx_ready = 1'b0;
    enq(3, 8'h3C, 1'b0); enq(3, 8'h3D, 1'b1);
    sb.push_back(8'h3C); sb.push_back(8'h3D);
    for (int i = 0; i < 10 && !tx_valid; i++) cyc(1);
    check("bp_load", {tx_valid, tx_data}, {1'b1, 8'h3C});
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      check("bp_hold", {tx_valid, tx_data, req_ready}, {1'b1, 8'h3C, 4'b0000});
    end
    tx_ready = 1'b1;
    #1;
    check("bp_ready_rise", req_ready, 4'b1000);
    cyc(1);
    check("bp_next_byte", {tx_valid, tx_data}, {1'b1, 8'h3D});
    wait_drain(20);

    // Forced release after MAX_BURST bytes, req2 waiting
    for (int k = 0; k < 4; k++) enq(1, 8'hA1 + 8'(k), 1'b0);
    enq(1, 8'hA5, 1'b1);
    enq(2, 8'hB2, 1'b1);
    for (int k = 0; k < 4; k++) sb.push_back(8'hA1 + 8'(k));
    sb.push_back(8'hB2); sb.push_back(8'hA5);
    for (int i = 0; i < 20 && !burst_err; i++) cyc(1);
    check("fr_berr_pulse", burst_err, 1);
    check("fr_released",   busy,      0);
    check("fr_last_owner", grant_id,  1);
    cyc(1);
    check("fr_berr_one_cycle", burst_err, 0);
    check("fr_new_grant",      grant_id,  2);
    check("fr_relocked",       busy,      1);
    wait_drain(40);

    // Reset mid-packet with a pending byte
    for (int k = 0; k < 5; k++) begin
      enq(0, 8'hC1 + 8'(k), k == 4);
      sb.push_back(8'hC1 + 8'(k));
    end
    for (int i = 0; i < 20 && !(tx_valid && tx_data == 8'hC2); i++) cyc(1);
    check("mr_second_byte", {tx_valid, tx_data}, {1'b1, 8'hC2});
    tx_ready = 1'b0;
    srst     = 1'b1;
    flush();
    #1;
    check("mr_ready_in_reset", req_ready, 0);
    cyc(1);
    check("mr_tx_valid", tx_valid,  0);
    check("mr_busy",     busy,      0);
    check("mr_ready",    req_ready, 0);
    check("mr_grant",    grant_id,  3);
    srst = 1'b0;
    #1;
    check("mr_ready_first_cycle", req_ready, 0);
    tx_ready = 1'b1;
    enq(2, 8'hD2, 1'b1); enq(0, 8'hD0, 1'b1);
    sb.push_back(8'hD0); sb.push_back(8'hD2);
    wait_drain(40);
    check("mr_prio_g0", glog[0], 0);
    check("mr_prio_g1", glog[1], 2);

    // Owner stall: req3 goes quiet mid-packet while req0 waits
    glog.delete();
    enq(3, 8'hE1, 1'b0);
    sb.push_back(8'hE1);
    cyc(4);
    enq(0, 8'hF0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      check("stall_hold", {grant_id, busy, req_ready[0]}, {2'd3, 1'b1, 1'b0});
    end
    enq(3, 8'hE2, 1'b1);
    sb.push_back(8'hE2); sb.push_back(8'hF0);
    wait_drain(40);
    check("stall_count", glog.size(), 3);
    check("stall_after", glog[2], 0);

    check("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, meaning number of requesters (2..8).
REQ-002 SHALL have parameter WIDTH, default 8, meaning data byte width.
REQ-003 SHALL have parameter MAX_BURST, default 64, meaning the maximum number of bytes per grant before forced release.
REQ-004 SHALL have port clk, input, 1 bit: single clock, all logic rising-edge.
REQ-005 SHALL have port srst, input, 1 bit: synchronous active-high reset.
REQ-006 SHALL have port req_valid, input, N_REQ bits: per-requester byte valid.
REQ-007 SHALL have port req_last, input, N_REQ bits: per-requester end-of-packet flag, qualified by req_valid.
REQ-008 SHALL have port req_data, input, N_REQ*WIDTH bits: requester i occupies bits [i*WIDTH +: WIDTH].
REQ-009 SHALL have port req_ready, output, N_REQ bits: per-requester accept.
REQ-010 SHALL have port tx_valid, output, 1 bit: byte offered to the UART TX engine.
REQ-011 SHALL have port tx_data, output, WIDTH bits: byte to the engine.
REQ-012 SHALL have port tx_ready, input, 1 bit: engine accepts a byte.
REQ-013 SHALL have port grant_id, output, $clog2(N_REQ) bits: index of the current or last owner.
REQ-014 SHALL have port busy, output, 1 bit: high while in the LOCKED state.
REQ-015 SHALL have port burst_err, output, 1 bit: one-cycle pulse on a forced release.

Function
REQ-016 SHALL implement states IDLE and LOCKED.
REQ-017 In IDLE with any req_valid set, SHALL select the first requester with req_valid set, searching circularly from grant_id+1.
- On that edge: load grant_id, move to LOCKED, clear burst_cnt.
- The arbitration cycle accepts no byte.
REQ-018 In IDLE with no req_valid set, SHALL remain in IDLE and keep grant_id unchanged.
REQ-019 SHALL drive req_ready[i] as (state==LOCKED && i==grant_id && (!tx_valid || tx_ready)), combinationally; all other bits 0.
REQ-020 SHALL treat requester accept as req_valid[g] && req_ready[g]. On accept:
- Register req_data[g] into tx_data and set tx_valid.
- Latency is 1 cycle.
REQ-021 SHALL clear tx_valid after a tx_valid && tx_ready handshake with no new accept in the same cycle.
REQ-022 SHALL keep tx_data and tx_valid stable while tx_valid && !tx_ready.
REQ-023 SHALL sustain full throughput: a same-cycle tx handshake and requester accept replace the byte with no bubble.
REQ-024 SHALL increment burst_cnt (width $clog2(MAX_BURST+1)) on each accept while LOCKED.
REQ-025 On an accept with req_last[g]=1, SHALL return to IDLE on the next edge.
REQ-026 On an accept that brings burst_cnt to MAX_BURST with req_last[g]=0, SHALL:
- Return to IDLE.
- Pulse burst_err for exactly one cycle.
REQ-027 SHALL not modify the byte held in tx_data or tx_valid on leaving LOCKED; the held byte drains normally.
REQ-028 SHALL allow re-arbitration in IDLE while tx_valid is still high; the new owner's first accept waits for tx_ready per REQ-019.
REQ-029 SHALL keep ownership if the owner drops req_valid mid-packet; there is no timeout other than MAX_BURST.
REQ-030 SHALL grant the same requester again after release only if no other requester is valid in the arbitration cycle.
REQ-031 SHALL ignore req_last when req_valid is low.

Reset
REQ-032 On srst=1 at a clock edge, SHALL set:
- state to IDLE
- tx_valid, burst_err and busy to 0
- tx_data to 0
- grant_id to N_REQ-1, so that requester 0 wins first
- burst_cnt to 0
REQ-033 srst SHALL take priority over every other event, including mid-packet and a pending tx byte; the pending byte is discarded.
REQ-034 req_ready SHALL be all-zero during reset and in the first cycle after reset.

Verification
REQ-035 Single requester: req0 sends 0x55,0xAA,0x00,0xFF (last on 0xFF) with tx_ready always 1. Required: tx_data 0x55,0xAA,0x00,0xFF on consecutive cycles after one arbitration cycle, busy falls after 0xFF, grant_id=0.
REQ-036 Round-robin: req0, req1 and req2 each hold a valid 1-byte packet. Required: grants in order 0,1,2; then after req0 re-requests, grant 0 follows 2.
REQ-037 Backpressure: tx_ready is held 0 for 10 cycles with tx_valid=1 and tx_data=0x3C. Required: tx_data stays 0x3C, req_ready[g]=0 throughout, and the next byte is accepted in the same cycle tx_ready rises.
REQ-038 Forced release: MAX_BURST=4, req1 streams with req_last=0 and req2 is valid. Required: after the 4th byte, burst_err pulses 1 cycle, and grant_id becomes 2 after the arbitration cycle.
REQ-039 Reset mid-packet: srst is asserted after the 2nd byte of a 5-byte packet while tx_ready=0. Required: next cycle tx_valid=0, busy=0, req_ready=0; after release, requester 0 has priority.
REQ-040 Owner stall: req3 is locked and drops req_valid for 20 cycles while req0 is valid. Required: grant stays 3 and req_ready[0]=0 until req3 sends last.
